// File: rtl/ram_fill_check.sv
// Fill-and-verify sequencer for a 16x2 dual-port synchronous RAM.
// Writes a seeded pattern through port A, reads it back through port B and tallies mismatches.
module ram_fill_check #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned STEP_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              we1,
  output logic              oe1,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] din_a,
  output logic              we2,
  output logic              oe2,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dout_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_cnt
);

  localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [StepW-1:0]  StepLast = StepW'(STEP_DIV - 1);
  localparam logic [StepW-1:0]  StepOne  = StepW'(1);
  localparam logic [ADDR_W-1:0] AddrLast = '1;
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ErrOne   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StCmp,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] din_a_q, din_a_d;
  logic              oe2_q, oe2_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic              tick;

  function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] s,
                                                 input logic [ADDR_W-1:0] a);
    return s + a[DATA_W-1:0];
  endfunction

  assign tick = (step_q == StepLast);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    step_d     = step_q;
    seed_d     = seed_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    pass_d     = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          seed_d     = seed;
          addr_d     = '0;
          step_d     = '0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          pass_d     = 1'b0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (tick) begin
          step_d = '0;
          if (addr_q == AddrLast) begin
            addr_d  = '0;
            state_d = StRead;
          end else begin
            addr_d = addr_q + AddrOne;
          end
        end else begin
          step_d = step_q + StepOne;
        end
      end
      StRead: begin
        if (tick) begin
          step_d  = '0;
          state_d = StCmp;
        end else begin
          step_d = step_q + StepOne;
        end
      end
      StCmp: begin
        if (dout_b != exp_data(seed_q, addr_q)) begin
          err_cnt_d = err_cnt_q + ErrOne;
          if (err_cnt_q == '0) begin
            err_addr_d = addr_q;
          end
        end
        step_d = '0;
        if (addr_q == AddrLast) begin
          state_d = StDone;
          pass_d  = (err_cnt_d == '0);
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so each one lands on the tick cycle itself;
  // the RAM then presents read data during the following CMP cycle.
  always_comb begin
    busy_d  = (state_d == StWrite) || (state_d == StRead) || (state_d == StCmp);
    done_d  = (state_d == StDone);
    we1_d   = (state_d == StWrite) && (step_d == StepLast);
    oe2_d   = (state_d == StRead) && (step_d == StepLast);
    addra_d = addra_q;
    din_a_d = din_a_q;
    addrb_d = addrb_q;
    if (we1_d) begin
      addra_d = addr_d;
      din_a_d = exp_data(seed_d, addr_d);
    end
    if (oe2_d) begin
      addrb_d = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      step_q     <= '0;
      seed_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we1_q      <= 1'b0;
      addra_q    <= '0;
      din_a_q    <= '0;
      oe2_q      <= 1'b0;
      addrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      seed_q     <= seed_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we1_q      <= we1_d;
      addra_q    <= addra_d;
      din_a_q    <= din_a_d;
      oe2_q      <= oe2_d;
      addrb_q    <= addrb_d;
    end
  end

  assign we1      = we1_q;
  assign oe1      = 1'b0;
  assign addra    = addra_q;
  assign din_a    = din_a_q;
  assign we2      = 1'b0;
  assign oe2      = oe2_q;
  assign addrb    = addrb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ram_fill_check.sv
// Bench for ram_fill_check: two instances (STEP_DIV 1 and 4), each with a RAM model and a
// timeline-based reference model checked every cycle.
module tb_ram_fill_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v      [2];
  logic       start_v    [2];
  logic [1:0] seed_v     [2];
  logic       we1_w      [2];
  logic       oe1_w      [2];
  logic       we2_w      [2];
  logic       oe2_w      [2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic       pass_w     [2];
  logic [3:0] addra_w    [2];
  logic [3:0] addrb_w    [2];
  logic [3:0] err_addr_w [2];
  logic [1:0] din_a_w    [2];
  logic [4:0] err_cnt_w  [2];
  logic       fault_en   [2][16];
  logic [1:0] fault_val  [2][16];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = (g == 0) ? 1 : 4;
    localparam int T = 16 * S + 16 * (S + 1);

    logic [1:0] dout_b = 2'b00;
    logic [1:0] mem [16];

    ram_fill_check #(
      .ADDR_W  (4),
      .DATA_W  (2),
      .STEP_DIV(S)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .start   (start_v[g]),
      .seed    (seed_v[g]),
      .we1     (we1_w[g]),
      .oe1     (oe1_w[g]),
      .addra   (addra_w[g]),
      .din_a   (din_a_w[g]),
      .we2     (we2_w[g]),
      .oe2     (oe2_w[g]),
      .addrb   (addrb_w[g]),
      .dout_b  (dout_b),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .pass    (pass_w[g]),
      .err_addr(err_addr_w[g]),
      .err_cnt (err_cnt_w[g])
    );

    // Synchronous RAM: read data appears the cycle after oe2; faults override stored data.
    always @(posedge clk) begin
      if (we1_w[g]) mem[addra_w[g]] <= din_a_w[g];
      if (oe2_w[g]) dout_b <= fault_en[g][addrb_w[g]] ? fault_val[g][addrb_w[g]]
                                                      : mem[addrb_w[g]];
    end

    // Reference: t counts busy cycles from 1; strobe positions follow from t directly.
    int         t      = 0;
    bit         active = 0;
    bit         done_m = 0;
    bit         fresh  = 1;
    bit         mpass  = 0;
    logic [1:0] mseed  = 2'b00;
    int         ecnt   = 0;
    int         eaddr  = 0;

    always @(posedge clk) begin
      if (rst_v[g]) begin
        active = 0;
        done_m = 0;
        fresh  = 1;
      end else if (!active && start_v[g]) begin
        active = 1;
        done_m = 0;
        fresh  = 0;
        mseed  = seed_v[g];
        t      = 1;
      end else if (active) begin
        if (t == T) begin
          active = 0;
          done_m = 1;
          ecnt   = 0;
          eaddr  = 0;
          for (int a = 0; a < 16; a++) begin
            if (fault_en[g][a] && fault_val[g][a] != 2'(mseed + a)) begin
              if (ecnt == 0) eaddr = a;
              ecnt++;
            end
          end
          mpass = (ecnt == 0);
        end else begin
          t++;
        end
      end
    end

    bit ew, eo;
    int ea, eb;

    always @(negedge clk) begin
      ew = 0;
      eo = 0;
      ea = 0;
      eb = 0;
      if (active) begin
        if (t <= 16 * S && t % S == 0) begin
          ew = 1;
          ea = t / S - 1;
        end else if (t > 16 * S && (t - 16 * S) % (S + 1) == S) begin
          eo = 1;
          eb = (t - 16 * S) / (S + 1);
        end
      end
      check($sformatf("i%0d t%0d busy", g, t), busy_w[g], active);
      check($sformatf("i%0d t%0d done", g, t), done_w[g], done_m);
      check($sformatf("i%0d t%0d we1", g, t), we1_w[g], ew);
      check($sformatf("i%0d t%0d oe2", g, t), oe2_w[g], eo);
      check($sformatf("i%0d oe1", g), oe1_w[g], 0);
      check($sformatf("i%0d we2", g), we2_w[g], 0);
      if (ew) begin
        check($sformatf("i%0d t%0d addra", g, t), addra_w[g], ea);
        check($sformatf("i%0d t%0d din_a", g, t), din_a_w[g], 2'(mseed + ea));
      end
      if (eo) check($sformatf("i%0d t%0d addrb", g, t), addrb_w[g], eb);
      if (fresh) begin
        check($sformatf("i%0d idle addra", g), addra_w[g], 0);
        check($sformatf("i%0d idle din_a", g), din_a_w[g], 0);
        check($sformatf("i%0d idle addrb", g), addrb_w[g], 0);
        check($sformatf("i%0d idle err_cnt", g), err_cnt_w[g], 0);
        check($sformatf("i%0d idle err_addr", g), err_addr_w[g], 0);
        check($sformatf("i%0d idle pass", g), pass_w[g], 0);
      end
      if (active) check($sformatf("i%0d busy pass", g), pass_w[g], 0);
      if (done_m) begin
        check($sformatf("i%0d done pass", g), pass_w[g], mpass);
        check($sformatf("i%0d done err_cnt", g), err_cnt_w[g], ecnt);
        check($sformatf("i%0d done err_addr", g), err_addr_w[g], eaddr);
      end
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++) begin
        fault_en[i][a]  = 1'b0;
        fault_val[i][a] = 2'b00;
      end
  endtask

  task automatic pulse_start(input int idx, input logic [1:0] sd);
    @(negedge clk);
    start_v[idx] = 1'b1;
    seed_v[idx]  = sd;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    bit got = 0;
    for (int c = 0; c < 2000; c++) begin
      if (done_w[idx]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("wait_done timeout", 0, 1);
  endtask

  task automatic run(input int idx, input logic [1:0] sd, output int bcyc, output int wcnt,
                     output int first_din, output int min_sp, output int max_sp);
    int last = -1;
    bit got  = 0;
    bcyc      = 0;
    wcnt      = 0;
    first_din = -1;
    min_sp    = 1 << 30;
    max_sp    = 0;
    pulse_start(idx, sd);
    for (int c = 0; c < 2000; c++) begin
      if (done_w[idx]) begin
        got = 1;
        break;
      end
      if (busy_w[idx]) bcyc++;
      if (we1_w[idx]) begin
        if (wcnt == 0) first_din = din_a_w[idx];
        else begin
          if (c - last < min_sp) min_sp = c - last;
          if (c - last > max_sp) max_sp = c - last;
        end
        last = c;
        wcnt++;
      end
      @(negedge clk);
    end
    if (!got) check("run timeout", 0, 1);
  endtask

  task automatic idle_watch(input int idx, input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (we1_w[idx] || oe2_w[idx]) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int bcyc, wcnt, fdin, mins, maxs, pulses;
    bit found;
    for (int i = 0; i < 2; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      seed_v[i]  = 2'b00;
    end
    clear_faults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Reset then idle.
    idle_watch(0, 20, pulses);
    check("idle strobes", pulses, 0);
    check("idle busy", busy_w[0], 0);

    // Clean pass, seed 1.
    run(0, 2'b01, bcyc, wcnt, fdin, mins, maxs);
    check("clean busy cycles", bcyc, 48);
    check("clean we1 count", wcnt, 16);
    check("clean first din_a", fdin, 1);
    check("clean we1 spacing", maxs, 1);
    check("clean pass", pass_w[0], 1);
    check("clean err_cnt", err_cnt_w[0], 0);

    // Injected faults at addresses 5 and 9, seed 0.
    fault_en[0][5] = 1'b1;
    fault_val[0][5] = 2'b00;
    fault_en[0][9] = 1'b1;
    fault_val[0][9] = 2'b11;
    run(0, 2'b00, bcyc, wcnt, fdin, mins, maxs);
    check("fault err_cnt", err_cnt_w[0], 2);
    check("fault err_addr", err_addr_w[0], 5);
    check("fault pass", pass_w[0], 0);
    clear_faults();

    // Step divider of 4.
    run(1, 2'b10, bcyc, wcnt, fdin, mins, maxs);
    check("div4 busy cycles", bcyc, 144);
    check("div4 we1 count", wcnt, 16);
    check("div4 min spacing", mins, 4);
    check("div4 max spacing", maxs, 4);
    check("div4 pass", pass_w[1], 1);

    // Start while busy is ignored; restart from DONE uses the new seed.
    pulse_start(0, 2'b01);
    repeat (8) @(negedge clk);
    start_v[0] = 1'b1;
    seed_v[0]  = 2'b11;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    check("ignored start done", done_w[0], 1);
    start_v[0] = 1'b1;
    seed_v[0]  = 2'b11;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("restart done drop", done_w[0], 0);
    check("restart busy", busy_w[0], 1);
    wait_done(0);

    // Reset during the READ of address 7.
    pulse_start(0, 2'b10);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (oe2_w[0] && addrb_w[0] == 4'd7) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("read addr7 seen", found, 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("midrst busy", busy_w[0], 0);
    check("midrst oe2", oe2_w[0], 0);
    check("midrst addrb", addrb_w[0], 0);
    idle_watch(0, 20, pulses);
    check("post-reset strobes", pulses, 0);

    // Randomized runs with random faults on both step settings.
    for (int r = 0; r < 6; r++) begin
      int idx = r % 2;
      for (int a = 0; a < 16; a++) begin
        fault_en[idx][a]  = ($urandom_range(0, 3) == 0);
        fault_val[idx][a] = 2'($urandom);
      end
      run(idx, 2'($urandom), bcyc, wcnt, fdin, mins, maxs);
      check("random we1 count", wcnt, 16);
      clear_faults();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fill_check.md
# ram_fill_check

Upstream access sequencer for the 16x2 dual-port synchronous RAM. On a start request it writes a seeded test pattern to every address through port A, then reads every address back through port B and compares against the expected pattern. It reports pass/fail, the first failing address and an error count, which the display stage shows. A step divider slows each access so board users can watch the sequence on the seven-segment display.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (depth 2^ADDR_W = 16)
- DATA_W, 2, RAM data width
- STEP_DIV, 25_000_000, clk cycles per access step; legal range ≥1; bench uses 1 and 4

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  level; sampled each cycle, acted on only in IDLE or DONE
- seed  in  DATA_W  pattern seed; latched when start is accepted
- we1  out  1  port A write enable
- oe1  out  1  port A read enable; constant 0
- addra  out  ADDR_W  port A address
- din_a  out  DATA_W  port A write data
- we2  out  1  port B write enable; constant 0
- oe2  out  1  port B read enable
- addrb  out  ADDR_W  port B address
- dout_b  in  DATA_W  port B read data
- busy  out  1  high from start acceptance until DONE
- done  out  1  level; high in DONE until the next accepted start or rst
- pass  out  1  valid while done=1; 1 iff err_cnt==0
- err_addr  out  ADDR_W  first mismatching address; 0 if none
- err_cnt  out  ADDR_W+1  number of mismatches, 0..16

## Operation
- Expected data for address a: exp(a) = (seed_latched + a[DATA_W-1:0]) mod 2^DATA_W.
- FSM states: IDLE, WRITE, READ, CMP, DONE.
- IDLE/DONE: start=1 -> latch seed; clear addr counter, step counter, err_cnt, err_addr, pass, done; go to WRITE.
- Step tick: step counter runs only in WRITE/READ. It counts 0..STEP_DIV-1 and ticks when it reaches STEP_DIV-1, then wraps to 0. It is cleared on every entry to WRITE and READ.
- WRITE: on tick, drive we1=1 for exactly one cycle with addra=addr and din_a=exp(addr).
  - If addr==15: addr wraps to 0 and the FSM goes to READ.
  - Otherwise addr increments.
- READ: on tick, drive oe2=1 for exactly one cycle with addrb=addr, then go to CMP.
- CMP: sample dout_b, which the RAM presents the cycle after the oe2 cycle.
  - On mismatch: increment err_cnt; on the first mismatch, also load err_addr=addr.
  - If addr==15: go to DONE and set pass=(final err_cnt==0).
  - Otherwise addr increments and the FSM returns to READ.
- DONE: busy=0, done=1; all RAM strobes low.
- start while busy is ignored. seed changes after acceptance have no effect.
- All outputs are registered. we1 and oe2 are never high outside their single strobe cycle.

## Timing
- Reset values: we1=0, oe1=0, addra=0, din_a=0, we2=0, oe2=0, addrb=0, busy=0, done=0, pass=0, err_addr=0, err_cnt=0; state=IDLE.
- rst mid-operation: all outputs take reset values on the next edge. A partially completed write sequence is abandoned with no further strobes.
- start accepted at edge k: busy=1 and state=WRITE from k+1.
- First we1 pulse occurs STEP_DIV cycles after entering WRITE.
- STEP_DIV=1:
  - we1 is high on 16 consecutive cycles (addresses 0..15).
  - Then there are 16 READ/CMP pairs, with oe2 high on alternate cycles.
  - busy is high for exactly 48 cycles; done rises on the cycle busy falls.
- General case: busy duration = 16·STEP_DIV + 16·(STEP_DIV+1) cycles.
- err_cnt saturation is not needed: the maximum is 16, which fits in ADDR_W+1 bits.

## Test plan
- Reset then idle: rst=1 for 2 cycles, start=0 for 20 cycles -> all outputs 0, no we1 or oe2 pulses.
- Clean pass, STEP_DIV=1, seed=2'b01, bench RAM model -> we1 at addresses 0..15 with din_a=1,2,3,0,1,…; busy high 48 cycles; done=1, pass=1, err_cnt=0, err_addr=0.
- Injected fault: bench RAM forces dout_b=2'b00 at address 5 and 2'b11 at address 9, seed=0. Expected values are 1 and 1 -> err_cnt=2, err_addr=5, pass=0.
- Step divider, STEP_DIV=4: spacing between consecutive we1 pulses is 4 cycles; busy high 16·4+16·5=144 cycles.
- Start while busy, plus restart: pulse start with seed=3 at cycle 10 of a run -> ignored, run completes with the original seed. Start again in DONE -> done drops next cycle and a new run begins with the new seed.
- Reset mid-run: assert rst during the READ of address 7 -> next cycle all outputs 0 and state IDLE; no oe2 follows until a new start.
